// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Generates 640x480@60 Hz VGA timing on the 100 MHz system clock. The screen
// position advances only on clocks where pixel_en is high. Timing is counted
// in pixel_en events, not in clocks, so irregular strobe spacing is tolerated.
// Every output is registered. Each output is computed from the *next* counter
// values, so sync, video_on and the pulses always describe the same pixel as
// the pixel_x/pixel_y that appear in the same cycle.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active low
//   pixel_en    in   one-clk pixel advance strobe
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  high while (pixel_x, pixel_y) lies in the visible area
//   pixel_x     out  current column, 0..H_TOTAL-1
//   pixel_y     out  current line,   0..V_TOTAL-1
//   line_start  out  one-clk pulse when pixel_x becomes 0
//   frame_start out  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          video_on_next;
  logic          line_start_next;
  logic          frame_start_next;

  // State and output registers. Reset parks everything at the idle values:
  // sync lines deasserted (high), blanked, counters at the origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      pixel_x     <= x_next;
      pixel_y     <= y_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      video_on    <= video_on_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end
  end

  // Next-state and next-output logic. The very first strobe after reset
  // only starts the generator: it marks the origin pixel as the start of a
  // frame without moving the counters. Later strobes step the raster.
  always_comb begin
    state_next       = state;
    x_next           = pixel_x;
    y_next           = pixel_y;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;

    case (state)
      IDLE: begin
        if (pixel_en) begin
          state_next       = RUN;
          line_start_next  = 1'b1;
          frame_start_next = 1'b1;
        end
      end
      RUN: begin
        if (pixel_en) begin
          if (pixel_x == H_LAST) begin
            x_next          = '0;
            line_start_next = 1'b1;
            if (pixel_y == V_LAST) begin
              y_next           = '0;
              frame_start_next = 1'b1;
            end else begin
              y_next = pixel_y + CW'(1);
            end
          end else begin
            x_next = pixel_x + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Decoded from the next position so they line up with the counters.
    hsync_next    = !((x_next >= H_SYNC_BEG) && (x_next < H_SYNC_END));
    vsync_next    = !((y_next >= V_SYNC_BEG) && (y_next < V_SYNC_END));
    video_on_next = (state_next == RUN) && (x_next < H_VIS_END) &&
                    (y_next < V_VIS_END);
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the 25 MHz `pixel_en` strobe from the clock-enable dividers and produces 640x480@60 Hz VGA timing.
- Outputs: `hsync`, `vsync`, `video_on`, the current pixel coordinates, and line/frame start pulses.
- Runs entirely on the 100 MHz system clock. `pixel_en` is the only advance qualifier; no derived clocks.
- Sits between the clock-enable dividers and the pixel/colour generation logic.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CW, 10, coordinate counter width; H_TOTAL and V_TOTAL must each be <= 2^CW

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-low reset
- pixel_en  input  1  one-clk-wide pixel advance strobe, normally every 4th clk
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  output  CW  current column, 0..H_TOTAL-1
- pixel_y  output  CW  current line, 0..V_TOTAL-1
- line_start  output  1  one-clk pulse when pixel_x becomes 0
- frame_start  output  1  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registered. Sync, video_on and the pulses are computed from the next counter values, so in every clk cycle they are coherent with pixel_x/pixel_y.
- Reset (reset=0, asynchronous) gives state IDLE and these output values:
  - pixel_x=0, pixel_y=0
  - hsync=1, vsync=1
  - video_on=0, line_start=0, frame_start=0
- Two-state FSM:
  - IDLE: counters frozen at (0,0), outputs at reset values. On the first clk edge with pixel_en=1 the block enters RUN; that edge sets video_on=1, line_start=1, frame_start=1, and the counters stay at (0,0).
  - RUN: each clk edge with pixel_en=1 advances pixel_x. If pixel_x==H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments. If pixel_y==V_TOTAL-1 at that point, pixel_y also wraps to 0. With pixel_en=0 everything holds, and the pulses drop to 0.
  - RUN never returns to IDLE except via reset.
- hsync=0 iff H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- vsync=0 iff V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491. vsync changes only at line boundaries, together with the pixel_x wrap.
- video_on=1 iff pixel_x<H_VISIBLE and pixel_y<V_VISIBLE (RUN only).
- line_start:
  - High for exactly the one clk cycle following an advance that results in pixel_x=0.
  - Also asserted for the IDLE->RUN transition.
- frame_start: same rule as line_start, but for the advance to (0,0). It coincides with a line_start.
- pixel_en held high continuously is legal: counters advance every clk with the same rules.
- pixel_en with irregular spacing is legal: timing is counted in pixel_en events, not clks.
- Reset asserted mid-frame: immediate return to IDLE and reset values, regardless of clk. After release, the block waits for pixel_en again.
- No other wrap/overflow conditions exist: counters never exceed H_TOTAL-1 / V_TOTAL-1.
- Frame period with default parameters and pixel_en every 4th clk: 420,000 pixel_en = 1,680,000 clk (16.8 ms).

Test Plan:
- Reset 0 then 1, pixel_en=0 for 20 clk -> outputs hold hsync=1, vsync=1, video_on=0, x=y=0, no pulses.
- First pixel_en after release -> next cycle frame_start=1, line_start=1, video_on=1, (0,0). Pulses last 1 clk; after 4 clk with pixel_en every 4th clk, x=1.
- Run one line with pixel_en every 4th clk:
  - video_on falls when x becomes 640.
  - hsync falls when x becomes 656 and rises when x becomes 752.
  - x=799 -> 0 wraps, y becomes 1, line_start pulses once.
- Run a full frame:
  - vsync low only for y=490..491.
  - video_on stays 0 for y>=480.
  - The (799,524)->(0,0) wrap gives frame_start.
  - Successive frame_starts are 1,680,000 clk apart.
- pixel_en tied high -> identical sequence compressed: 800 clk per line, 420,000 clk per frame.
- Assert reset at (300,200) mid-line -> asynchronous return to reset values within the same cycle. After release plus pixel_en, frame_start reappears at (0,0).
